can_if_array: RTL and testbench
===============================

# can_if_array

Parametrised N-channel CAN interface fabric between the OPB register bus and N CORECAN_wrapper cores. It sits where the fixed 4-channel CAN interface sits today:
- Decodes one CAN RE/WE strobe pair into per-channel strobes by address.
- Muxes and registers channel read data.
- Adds a control block: per-channel mode (normal / loopback / listen-only / disabled), pin RX synchronisation, a stuck-dominant detector with TX lockout, and bus-activity flags.

## Interface
- NUM_CH, 4, number of channels, 1..8
- CH_SEL_LSB, 12, LSB of the 4-bit channel-select field OPB_ADDR[CH_SEL_LSB+3:CH_SEL_LSB]
- STUCK_CYCLES, 4096, consecutive dominant cycles that declare a channel stuck, ≥2
- OPB_CLK  in  1  sole clock; everything is synchronous to its rising edge
- OPB_RST  in  1  synchronous, active-high reset
- OPB_ADDR  in  16  register address
- OPB_DI  in  32  write data
- CAN_RE  in  1  read strobe for the whole CAN space
- CAN_WE  in  1  write strobe for the whole CAN space
- OPB_DO  out  32  registered read data
- CH_RE  out  NUM_CH  per-core read strobe
- CH_WE  out  NUM_CH  per-core write strobe
- CH_DO  in  32*NUM_CH  core read data; channel i occupies bits [32i+31:32i]
- CORE_TX  in  NUM_CH  core TX outputs
- CORE_RX  out  NUM_CH  core RX inputs
- CAN_TX  out  NUM_CH  pin TX
- CAN_RX  in  NUM_CH  pin RX, asynchronous

## Operation
**Address decode**
- sel = OPB_ADDR[CH_SEL_LSB+3:CH_SEL_LSB].
- sel < NUM_CH: channel access. CH_RE[sel] = CAN_RE and CH_WE[sel] = CAN_WE, combinational, same cycle. OPB_ADDR and OPB_DI go to the cores unmodified.
- sel = 4'hF: control block, word offset OPB_ADDR[3:2].
- Any other sel: no strobe is issued, a read returns 0, and STATUS[31] (decode error, sticky) is set.

**Control registers**
- 0 CTRL (RW): bits [2i+1:2i] select the mode of channel i. Unused bits read 0.
  - 00 normal
  - 01 internal loopback
  - 10 listen-only
  - 11 disabled
- 1 STATUS (W1C): bit i = stuck-dominant flag of channel i; bit 8+i = activity flag of channel i; bit 31 = decode error.
- 2 ID (RO): {8'hCA, 8'h01, 8'h00, NUM_CH[7:0]}.
- 3: reads 0, writes are ignored.

**RX path**
- Each CAN_RX passes through a 2-FF synchroniser (rxs), reset value 1.
- Activity flag sets on a 1→0 transition of rxs.

**Mode mux, channel i**
- normal: CORE_RX = rxs; CAN_TX = CORE_TX.
- loopback: CORE_RX = CORE_TX (combinational); CAN_TX = 1.
- listen-only: CORE_RX = rxs & CORE_TX; CAN_TX = 1.
- disabled: CORE_RX = 1; CAN_TX = 1.
- While the stuck flag is set, CAN_TX = 1 in every mode.

**Stuck detector, per channel, active in all modes**
- Counter width is clog2(STUCK_CYCLES+1).
- rxs = 1 clears the counter.
- rxs = 0 increments the counter, saturating at STUCK_CYCLES.
- Reaching STUCK_CYCLES sets the stuck flag.
- A W1C of the stuck flag also clears the counter. If the bus is still dominant, the flag re-sets STUCK_CYCLES cycles later.

## Timing
- **Reset:**
  - OPB_DO = 0; CTRL = 0; all flags = 0; counters = 0; rxs = 1.
  - CH_RE = CH_WE = 0.
  - CAN_TX = CORE_TX (normal mode).
- **Read latency:** 1 cycle.
  - OPB_DO loads on the edge ending the CAN_RE cycle, from CH_DO[sel] or the control register sampled in that cycle.
  - OPB_DO holds until the next CAN_RE.
  - Cores must present CH_DO during the CAN_RE cycle.
- **Writes** take effect on the edge ending the CAN_WE cycle. A new CTRL mode drives the mux from the next cycle.
- **RE and WE in the same cycle** to a control register: the write happens and the read returns the pre-write value.
- **Simultaneous set and W1C** of the same flag: set wins.
- **RX latency:** a CAN_RX edge reaches rxs 2 cycles later, and the activity flag 3 cycles later.
- **Stuck detection:** the flag sets exactly STUCK_CYCLES cycles after rxs first goes 0. CAN_TX is forced to 1 in the same cycle the flag becomes visible.
- **Reset mid-operation:** all state returns to reset values at the next edge; a core access in progress is discarded.

## Test plan
- **Channel strobes:** NUM_CH=4, CH_SEL_LSB=12. Read at 0x2000 with CH_DO[2] = 0x1234_5678 → only CH_RE[2] pulses, and OPB_DO = 0x1234_5678 one cycle later. Write at 0x3004 → only CH_WE[3] pulses.
- **Decode error:** read at 0x5000 → no CH_RE, OPB_DO = 0. A subsequent STATUS read (0xF004) returns bit31 = 1. Writing 0x8000_0000 clears it.
- **Modes:** write CTRL = 0x0000_00E4 → ch0 normal, ch1 loopback (CORE_RX[1] tracks CORE_TX[1], CAN_TX[1] = 1), ch2 listen-only, ch3 disabled (CORE_RX[3] = 1, CAN_TX[3] = 1). ID reads 0xCA01_0004.
- **Stuck detector:** STUCK_CYCLES=16; hold CAN_RX[0] = 0.
  - STATUS[0] sets 18 cycles after the pin edge; CAN_TX[0] = 1 despite CORE_TX[0] = 0.
  - W1C 0x1 while still dominant → the flag re-sets 16 cycles later.
  - Release RX, then W1C → CAN_TX follows CORE_TX again.
- **Activity flag and clear collision:** pulse CAN_RX[1] low → STATUS[9] set 3 cycles after the edge. A W1C coinciding with a new falling edge leaves the bit set.
- **Mid-operation reset:** assert OPB_RST during the stuck count and with CTRL ≠ 0 → all outputs take reset values next cycle, and the count restarts from 0.

Source files
------------

// File: rtl/can_if_array.sv
// N-channel CAN interface fabric between the OPB register bus and the CAN cores.
// Decodes per-channel strobes, registers read data and adds mode, RX sync and stuck-dominant control.
module can_if_array #(
    parameter int NUM_CH       = 4,
    parameter int CH_SEL_LSB   = 12,
    parameter int STUCK_CYCLES = 4096
) (
    input  logic                  OPB_CLK,
    input  logic                  OPB_RST,
    input  logic [15:0]           OPB_ADDR,
    input  logic [31:0]           OPB_DI,
    input  logic                  CAN_RE,
    input  logic                  CAN_WE,
    output logic [31:0]           OPB_DO,
    output logic [NUM_CH-1:0]     CH_RE,
    output logic [NUM_CH-1:0]     CH_WE,
    input  logic [32*NUM_CH-1:0]  CH_DO,
    input  logic [NUM_CH-1:0]     CORE_TX,
    output logic [NUM_CH-1:0]     CORE_RX,
    output logic [NUM_CH-1:0]     CAN_TX,
    input  logic [NUM_CH-1:0]     CAN_RX
);

    localparam int              CW      = $clog2(STUCK_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STUCK_CYCLES);
    localparam logic [CW-1:0]   CNT_PRE = CW'(STUCK_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [3:0]      SEL_CTL = 4'hF;
    localparam logic [3:0]      SEL_NCH = 4'(NUM_CH);
    localparam logic [31:0]     ID_WORD = {8'hCA, 8'h01, 8'h00, 8'(NUM_CH)};

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_LOOP   = 2'b01,
        MODE_LISTEN = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

    logic [3:0]          w_sel;
    logic [1:0]          w_ofs;
    logic                w_chHit;
    logic                w_ctlHit;
    logic                w_ctrlWr;
    logic                w_statWr;
    logic                w_decErr;
    logic [31:0]         w_rdData;
    logic [31:0]         w_status;
    logic [31:0]         w_ctrlWord;
    logic [NUM_CH-1:0]   w_actSet;
    logic [NUM_CH-1:0]   w_actClr;
    logic [NUM_CH-1:0]   w_stuckSet;
    logic [NUM_CH-1:0]   w_stuckClr;
    logic                w_unused;

    logic [31:0]         r_opbDo;
    logic [2*NUM_CH-1:0] r_ctrl;
    logic                r_decErr;
    logic [NUM_CH-1:0]   r_rxMeta;
    logic [NUM_CH-1:0]   r_rxs;
    logic [NUM_CH-1:0]   r_rxsPrev;
    logic [NUM_CH-1:0]   r_act;
    logic [NUM_CH-1:0]   r_stuck;
    logic [CW-1:0]       r_cnt [NUM_CH];

    assign w_sel    = OPB_ADDR[CH_SEL_LSB+3:CH_SEL_LSB];
    assign w_ofs    = OPB_ADDR[3:2];
    assign w_chHit  = (w_sel < SEL_NCH);
    assign w_ctlHit = (w_sel == SEL_CTL);
    assign w_ctrlWr = CAN_WE & w_ctlHit & (w_ofs == 2'd0);
    assign w_statWr = CAN_WE & w_ctlHit & (w_ofs == 2'd1);
    assign w_decErr = (CAN_RE | CAN_WE) & ~w_chHit & ~w_ctlHit;
    assign OPB_DO   = r_opbDo;

    // Address and data bits outside the decode fields are only meaningful to the cores.
    assign w_unused = ^{OPB_ADDR, OPB_DI};

    assign w_actSet   = r_rxsPrev & ~r_rxs;
    assign w_actClr   = {NUM_CH{w_statWr}} & OPB_DI[8 +: NUM_CH];
    assign w_stuckClr = {NUM_CH{w_statWr}} & OPB_DI[NUM_CH-1:0];

    always_comb begin
        CH_RE = '0;
        CH_WE = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((w_sel == 4'(i)) && !OPB_RST) begin
                CH_RE[i] = CAN_RE;
                CH_WE[i] = CAN_WE;
            end
        end
    end

    always_comb begin
        w_status                = '0;
        w_status[NUM_CH-1:0]    = r_stuck;
        w_status[8 +: NUM_CH]   = r_act;
        w_status[31]            = r_decErr;
        w_ctrlWord              = '0;
        w_ctrlWord[2*NUM_CH-1:0] = r_ctrl;
    end

    always_comb begin
        w_rdData = '0;
        if (w_ctlHit) begin
            case (w_ofs)
                2'd0:    w_rdData = w_ctrlWord;
                2'd1:    w_rdData = w_status;
                2'd2:    w_rdData = ID_WORD;
                default: w_rdData = '0;
            endcase
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_sel == 4'(i)) w_rdData = CH_DO[32*i +: 32];
            end
        end
    end

    // Only the increment that lands on the threshold sets the flag, so a saturated counter cannot block a clear.
    always_comb begin
        w_stuckSet = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_stuckSet[i] = ~r_rxs[i] && (r_cnt[i] == CNT_PRE);
        end
    end

    always_comb begin
        CORE_RX = '1;
        CAN_TX  = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode_e'(r_ctrl[2*i +: 2]))
                MODE_NORMAL: begin
                    CORE_RX[i] = r_rxs[i];
                    CAN_TX[i]  = CORE_TX[i];
                end
                MODE_LOOP:   CORE_RX[i] = CORE_TX[i];
                MODE_LISTEN: CORE_RX[i] = r_rxs[i] & CORE_TX[i];
                default:     ;
            endcase
            if (r_stuck[i]) CAN_TX[i] = 1'b1;
        end
    end

    always_ff @(posedge OPB_CLK) begin
        if (OPB_RST) begin
            r_opbDo   <= '0;
            r_ctrl    <= '0;
            r_decErr  <= 1'b0;
            r_rxMeta  <= '1;
            r_rxs     <= '1;
            r_rxsPrev <= '1;
            r_act     <= '0;
            r_stuck   <= '0;
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end else begin
            if (CAN_RE) r_opbDo <= w_rdData;
            if (w_ctrlWr) r_ctrl <= OPB_DI[2*NUM_CH-1:0];
            r_rxMeta  <= CAN_RX;
            r_rxs     <= r_rxMeta;
            r_rxsPrev <= r_rxs;
            r_decErr  <= w_decErr | (r_decErr & ~(w_statWr & OPB_DI[31]));
            r_act     <= w_actSet | (r_act & ~w_actClr);
            r_stuck   <= w_stuckSet | (r_stuck & ~w_stuckClr);
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_rxs[i] || w_stuckClr[i]) r_cnt[i] <= '0;
                else if (r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_can_if_array.sv
// Self-checking bench for can_if_array: directed steps then random traffic,
// all checked against a cycle-level behavioural model of the register and pin behaviour.
module tb_can_if_array;

    localparam int NCH = 4;
    localparam int LSB = 12;
    localparam int STK = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  addr;
    logic [31:0]  di;
    logic         re;
    logic         we;
    logic [31:0]  opbDo;
    logic [3:0]   chRe;
    logic [3:0]   chWe;
    logic [127:0] chDo;
    logic [3:0]   coreTx;
    logic [3:0]   coreRx;
    logic [3:0]   canTx;
    logic [3:0]   canRx;

    int total = 0;
    int bad   = 0;

    // Model state: pin history per channel (bit0 = newest sample), dominant run length since last clear.
    logic [7:0]  mCtrl;
    logic        mDecErr;
    logic [3:0]  mAct;
    logic [3:0]  mStuck;
    logic [31:0] mOpbDo;
    logic [3:0]  mHist [4];
    int          mRun  [4];

    always #5 clk = ~clk;

    can_if_array #(.NUM_CH(NCH), .CH_SEL_LSB(LSB), .STUCK_CYCLES(STK)) dut (
        .OPB_CLK(clk), .OPB_RST(rst), .OPB_ADDR(addr), .OPB_DI(di),
        .CAN_RE(re), .CAN_WE(we), .OPB_DO(opbDo), .CH_RE(chRe), .CH_WE(chWe),
        .CH_DO(chDo), .CORE_TX(coreTx), .CORE_RX(coreRx), .CAN_TX(canTx), .CAN_RX(canRx)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mCtrl   = '0;
        mDecErr = 1'b0;
        mAct    = '0;
        mStuck  = '0;
        mOpbDo  = '0;
        for (int c = 0; c < NCH; c++) begin
            mHist[c] = 4'b1111;
            mRun[c]  = 0;
        end
    endtask

    function automatic logic [31:0] modelRead();
        logic [3:0]  sel = addr[LSB+3:LSB];
        logic [31:0] st  = '0;
        st[3:0]  = mStuck;
        st[11:8] = mAct;
        st[31]   = mDecErr;
        if (int'(sel) < NCH) return chDo[32*int'(sel) +: 32];
        if (sel == 4'hF) begin
            case (addr[3:2])
                2'd0:    return {24'b0, mCtrl};
                2'd1:    return st;
                2'd2:    return 32'hCA01_0004;
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    task automatic modelEdge();
        logic [3:0]  sel   = addr[LSB+3:LSB];
        logic [31:0] rd    = modelRead();
        logic        statW = we && (sel == 4'hF) && (addr[3:2] == 2'd1);
        logic [3:0]  sSet, sClr, aSet, aClr;
        if (rst) begin
            modelReset();
        end else begin
            for (int c = 0; c < NCH; c++) begin
                aSet[c] = mHist[c][2] & ~mHist[c][1];
                sSet[c] = !mHist[c][1] && (mRun[c] + 1 == STK);
                sClr[c] = statW && di[c];
                aClr[c] = statW && di[8+c];
                if (sClr[c] || mHist[c][1]) mRun[c] = 0;
                else mRun[c] = mRun[c] + 1;
                mHist[c] = {mHist[c][2:0], canRx[c]};
            end
            mStuck  = sSet | (mStuck & ~sClr);
            mAct    = aSet | (mAct & ~aClr);
            mDecErr = ((re || we) && int'(sel) >= NCH && sel != 4'hF) || (mDecErr && !(statW && di[31]));
            if (re) mOpbDo = rd;
            if (we && sel == 4'hF && addr[3:2] == 2'd0) mCtrl = di[7:0];
        end
    endtask

    task automatic checkComb();
        logic [3:0] sel = addr[LSB+3:LSB];
        logic [3:0] expRe, expWe, expRx, expTx;
        logic [1:0] mode;
        expRe = (re && int'(sel) < NCH && !rst) ? (4'b0001 << sel) : 4'b0000;
        expWe = (we && int'(sel) < NCH && !rst) ? (4'b0001 << sel) : 4'b0000;
        for (int c = 0; c < NCH; c++) begin
            mode = mCtrl[2*c +: 2];
            expRx[c] = (mode == 2'd0) ? mHist[c][1] :
                       (mode == 2'd1) ? coreTx[c] :
                       (mode == 2'd2) ? (mHist[c][1] & coreTx[c]) : 1'b1;
            expTx[c] = (mode == 2'd0 && !mStuck[c]) ? coreTx[c] : 1'b1;
        end
        checkOutput("chRe", 32'(chRe), 32'(expRe));
        checkOutput("chWe", 32'(chWe), 32'(expWe));
        checkOutput("coreRx", 32'(coreRx), 32'(expRx));
        checkOutput("canTx", 32'(canTx), 32'(expTx));
    endtask

    // One bus cycle: inputs already driven just after the previous edge.
    task automatic applyStimulus();
        #1;
        checkComb();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("opbDo", opbDo, mOpbDo);
    endtask

    task automatic setBus(input logic [15:0] a, input logic [31:0] d, input logic r, input logic w);
        addr = a;
        di   = d;
        re   = r;
        we   = w;
    endtask

    initial begin
        rst = 1'b1; addr = '0; di = '0; re = 1'b0; we = 1'b0;
        chDo = '0; coreTx = 4'b1010; canRx = 4'hF;
        repeat (2) @(posedge clk);
        modelReset();
        #1;
        $display("[TB] reset state");
        checkOutput("rstOpbDo", opbDo, 32'h0);
        checkOutput("rstCanTx", 32'(canTx), 32'h0000_000A);
        checkOutput("rstChRe", 32'(chRe), 32'h0);
        rst = 1'b0;
        applyStimulus();

        $display("[TB] channel strobes");
        chDo = {$urandom, 32'h1234_5678, $urandom, $urandom};
        setBus(16'h2000, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("rdStrobe", 32'(chRe), 32'h4);
        checkOutput("rdData", opbDo, 32'h1234_5678);
        setBus(16'h3004, $urandom, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("wrStrobe", 32'(chWe), 32'h8);
        checkOutput("wrNoRe", 32'(chRe), 32'h0);

        $display("[TB] decode error");
        setBus(16'h5000, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("badSelNoRe", 32'(chRe), 32'h0);
        checkOutput("badSelData", opbDo, 32'h0);
        setBus(16'hF004, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("decErrSet", 32'(opbDo[31]), 32'h1);
        setBus(16'hF004, 32'h8000_0000, 1'b0, 1'b1);
        applyStimulus();
        setBus(16'hF004, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("decErrClr", 32'(opbDo[31]), 32'h0);

        $display("[TB] modes and ID");
        setBus(16'hF000, 32'h0000_00E4, 1'b0, 1'b1);
        applyStimulus();
        setBus(16'h0000, 32'h0, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            coreTx = 4'($urandom);
            applyStimulus();
            checkOutput("loopRx", 32'(coreRx[1]), 32'(coreTx[1]));
            checkOutput("loopTx", 32'(canTx[1]), 32'h1);
            checkOutput("offRx", 32'(coreRx[3]), 32'h1);
            checkOutput("offTx", 32'(canTx[3]), 32'h1);
        end
        setBus(16'hF008, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("idWord", opbDo, 32'hCA01_0004);
        setBus(16'hF000, 32'h0, 1'b1, 1'b1);
        applyStimulus();
        checkOutput("rdWrSame", opbDo, 32'h0000_00E4);
        setBus(16'hF000, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("ctrlCleared", opbDo, 32'h0);

        $display("[TB] stuck detector");
        setBus(16'h0000, 32'h0, 1'b0, 1'b0);
        coreTx = 4'h0;
        canRx[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus();
            checkOutput("stuckRise", 32'(canTx[0]), 32'(k >= 18));
        end
        setBus(16'hF004, 32'h1, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("stuckW1c", 32'(canTx[0]), 32'h0);
        setBus(16'h0000, 32'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus();
            checkOutput("stuckReset", 32'(canTx[0]), 32'(k == 16));
        end
        canRx[0] = 1'b1;
        repeat (3) applyStimulus();
        setBus(16'hF004, 32'h1, 1'b0, 1'b1);
        applyStimulus();
        setBus(16'h0000, 32'h0, 1'b0, 1'b0);
        coreTx[0] = 1'b1;
        applyStimulus();
        checkOutput("txFreeHi", 32'(canTx[0]), 32'h1);
        coreTx[0] = 1'b0;
        applyStimulus();
        checkOutput("txFreeLo", 32'(canTx[0]), 32'h0);

        $display("[TB] activity flag");
        setBus(16'hF004, 32'h0000_0F00, 1'b0, 1'b1);
        applyStimulus();
        setBus(16'hF004, 32'h0, 1'b1, 1'b0);
        canRx[1] = 1'b0;
        applyStimulus();
        canRx[1] = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("actEarly", 32'(opbDo[9]), 32'h0);
        applyStimulus();
        checkOutput("actSet", 32'(opbDo[9]), 32'h1);
        setBus(16'hF004, 32'h0000_0200, 1'b0, 1'b1);
        applyStimulus();
        setBus(16'hF004, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("actClr", 32'(opbDo[9]), 32'h0);
        setBus(16'h0000, 32'h0, 1'b0, 1'b0);
        canRx[1] = 1'b0;
        applyStimulus();
        canRx[1] = 1'b1;
        applyStimulus();
        setBus(16'hF004, 32'h0000_0200, 1'b0, 1'b1);
        applyStimulus();
        setBus(16'hF004, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("actCollide", 32'(opbDo[9]), 32'h1);

        $display("[TB] mid-operation reset");
        setBus(16'hF000, 32'h0000_00E4, 1'b0, 1'b1);
        applyStimulus();
        setBus(16'h0000, 32'h0, 1'b0, 1'b0);
        coreTx = 4'h0;
        canRx[0] = 1'b0;
        repeat (8) applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("midRstDo", opbDo, 32'h0);
        checkOutput("midRstTx", 32'(canTx), 32'h0);
        for (int k = 1; k <= 18; k++) begin
            applyStimulus();
            checkOutput("midRstCount", 32'(canTx[0]), 32'(k >= 18));
        end
        canRx = 4'hF;

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            rst  = ($urandom_range(0, 59) == 0);
            addr = 16'($urandom);
            if (kind < 5) addr[15:12] = 4'($urandom_range(0, NCH - 1));
            else if (kind < 8) addr[15:12] = 4'hF;
            else addr[15:12] = 4'($urandom_range(NCH, 14));
            re     = 1'($urandom);
            we     = ($urandom_range(0, 3) == 0);
            di     = $urandom;
            chDo   = {$urandom, $urandom, $urandom, $urandom};
            coreTx = 4'($urandom);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 23) == 0) canRx[c] = ~canRx[c];
            end
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
